rs_rr_arb: RTL and testbench
============================

# rs_rr_arb

Round-robin arbiter that merges REQ_NUM valid/ready payload streams onto one shared register-slice output. It sits in front of a single downstream consumer, chooses one requester per cycle, and registers the winning beat into a full-throughput output slice. Result: one-cycle latency and sustained 1 beat/cycle.

## Interface
- REQ_NUM, 4, number of requesters, 2..16
- PLD_WIDTH, 32, payload width per requester
- ID_WIDTH, $clog2(REQ_NUM), localparam, width of m_id
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_vld  in  REQ_NUM  per-requester valid
- s_pld  in  REQ_NUM*PLD_WIDTH  requester i payload at bits [i*PLD_WIDTH +: PLD_WIDTH]
- s_last  in  REQ_NUM  per-requester last-beat flag
- s_rdy  out  REQ_NUM  per-requester ready, at most one bit high
- m_vld  out  1  output valid
- m_pld  out  PLD_WIDTH  output payload
- m_id  out  ID_WIDTH  index of the source requester
- m_last  out  1  s_last of the source beat
- m_rdy  in  1  downstream ready

## Operation
- Handshake is valid/ready on both sides. A transfer occurs when vld and rdy are both high at a rising edge.
- Requesters must hold s_vld, s_pld and s_last stable until accepted. s_vld must not depend on s_rdy.
- Grant pointer ptr (ID_WIDTH bits, reset 0) marks the highest-priority requester. Priority order is ptr, ptr+1, … REQ_NUM-1, 0, … ptr-1.
- gnt is one-hot and combinational: the first requester with s_vld high in priority order. gnt is all zeros when no s_vld is high.
- Slice-side ready is int_rdy. s_rdy[i] = gnt[i] & int_rdy.
- On an accepted beat from requester g, ptr <= (g+1) mod REQ_NUM. When REQ_NUM is not a power of 2, the wrap happens explicitly at REQ_NUM-1 -> 0.
- The beat {pld, g, last} enters the output slice, then m_pld, m_id and m_last present it.
- The output slice is a 2-entry full slice. int_rdy is registered (depends only on slice occupancy). The slice holds up to 2 beats under m_rdy backpressure.
- No requester is starved: a continuously valid requester is granted within REQ_NUM accepted beats.
- Reset, asynchronous and asserted at any time:
  - Slice contents are dropped.
  - m_vld=0, m_pld=0, m_id=0, m_last=0.
  - ptr=0, lock cleared.
  - int_rdy=1 after release, so s_rdy = gnt.
  - In-flight beats are lost; requesters are reset alongside.

## Timing
- Latency: a beat accepted at edge N appears on m_vld after edge N, i.e. in cycle N+1.
- Throughput: 1 beat/cycle while m_rdy=1, including back-to-back beats from different requesters.
- Slice has 2 beats and m_rdy=0: int_rdy=0 from the next cycle, and all s_rdy are 0.
- Slice empties: int_rdy returns to 1 one cycle after the m_rdy handshake that frees an entry.
- Simultaneous accept on the input and drain on the output in the same cycle: occupancy is unchanged, with no bubble.
- Single requester streaming: granted every cycle, and ptr toggles past it each beat without effect.

## Configuration
- RS_ARB_LOCK_EN defined:
  - The grant is locked to requester g from its first accepted beat with s_last=0 until its accepted beat with s_last=1.
  - While locked, gnt = one-hot(g) regardless of other s_vld, and ptr does not advance.
  - On the s_last=1 accept, the lock clears and ptr <= (g+1) mod REQ_NUM.
  - If g drops s_vld while locked, the grant is still held and no other requester is served.
- RS_ARB_LOCK_EN undefined:
  - Arbitration is per beat.
  - s_last is passed to m_last only and has no effect on arbitration.

## Structure
- Package rs_pkg holds:
  - the function rr_pick(vld, ptr) returning the one-hot grant;
  - the localparam for the maximum REQ_NUM (16);
  - typedef rs_beat_t as a struct of {pld, id, last}, parameterised by width through macros in the package.
- Sub-module rs_rr_arb_slice is the 2-entry full output register slice storing rs_beat_t:
  - inputs: vld, beat, m_rdy;
  - outputs: int_rdy, m_vld, beat.
- The top level contains ptr, the lock state, grant mux, and payload mux.

## Test plan
- Reset check: hold rst_n=0 with s_vld=4'b1111 -> m_vld=0, m_pld=0, m_id=0. After release, with m_rdy=1, the first beat has m_id=0.
- Full contention: REQ_NUM=4, s_vld=4'b1111 held, m_rdy=1, payloads = requester index -> m_id sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles.
- Sparse requests: ptr=2, s_vld=4'b0011 -> requester 0 granted, then 1, then 0. Requester 3 never gets an s_rdy pulse.
- Backpressure:
  - m_rdy=0 for 3 cycles with s_vld=4'b0001 -> 2 beats accepted, then s_rdy=0.
  - m_rdy=1 -> beats emerge in order and no payload is lost or duplicated.
- Mid-stream reset: assert rst_n=0 while the slice holds 2 beats -> m_vld=0 immediately (asynchronous). After release, ptr restarts at 0.
- Lock (RS_ARB_LOCK_EN): requester 1 sends 3 beats with s_last=0,0,1 while requester 2 is valid throughout -> m_id=1,1,1, then 2. Without the macro -> m_id=1,2,1,2,1.

Source files
------------

// File: rtl/rs_pkg.sv
// rs_pkg: beat type, limits and round-robin pick shared by rs_rr_arb.
// Beat field widths come from RS_PLD_W / RS_ID_W (defaults 32 / 4).
`ifndef RS_PLD_W
`define RS_PLD_W 32
`endif
`ifndef RS_ID_W
`define RS_ID_W 4
`endif

package rs_pkg;

  localparam int RS_MAX_REQ    = 16;
  localparam int RS_PTR_W      = 4;
  localparam int RS_BEAT_PLD_W = `RS_PLD_W;
  localparam int RS_BEAT_ID_W  = `RS_ID_W;

  typedef struct packed {
    logic [RS_BEAT_PLD_W-1:0] pld;
    logic [RS_BEAT_ID_W-1:0]  id;
    logic                     last;
  } rs_beat_t;

  // Unused upper vld bits are zero, so the 16-wide wrap
  // matches a wrap at REQ_NUM-1.
  function automatic logic [RS_MAX_REQ-1:0] rr_pick(
    input logic [RS_MAX_REQ-1:0] vld,
    input logic [RS_PTR_W-1:0]   ptr
  );
    logic [RS_MAX_REQ-1:0] gnt;
    logic [RS_PTR_W-1:0]   idx;
    logic                  found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < RS_MAX_REQ; k++) begin
      idx = ptr + RS_PTR_W'(k);
      if (!found && vld[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rs_rr_arb_slice.sv
// rs_rr_arb_slice: 2-entry full-throughput output register slice.
// int_rdy_o is a pure register output (low only when the skid is full).
module rs_rr_arb_slice
  import rs_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     vld_i,
  input  rs_beat_t beat_i,
  input  logic     m_rdy_i,
  output logic     int_rdy_o,
  output logic     m_vld_o,
  output rs_beat_t beat_o
);

  logic     out_vld_q, out_vld_d;
  logic     skid_vld_q, skid_vld_d;
  rs_beat_t out_q, out_d;
  rs_beat_t skid_q, skid_d;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (skid_vld_q) begin
      if (m_rdy_i) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (vld_i) begin
      if (!out_vld_q || m_rdy_i) begin
        out_vld_d = 1'b1;
        out_d     = beat_i;
      end else begin
        skid_vld_d = 1'b1;
        skid_d     = beat_i;
      end
    end else if (m_rdy_i) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

  assign int_rdy_o = ~skid_vld_q;
  assign m_vld_o   = out_vld_q;
  assign beat_o    = out_q;

endmodule

// File: rtl/rs_rr_arb.sv
// rs_rr_arb: round-robin merge of REQ_NUM valid/ready streams into a slice.
// Define RS_ARB_LOCK_EN to hold the grant from a first beat to its s_last beat.
module rs_rr_arb
  import rs_pkg::*;
#(
  parameter  int REQ_NUM   = 4,
  parameter  int PLD_WIDTH = 32,
  localparam int ID_WIDTH  = $clog2(REQ_NUM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REQ_NUM-1:0]           s_vld,
  input  logic [REQ_NUM*PLD_WIDTH-1:0] s_pld,
  input  logic [REQ_NUM-1:0]           s_last,
  output logic [REQ_NUM-1:0]           s_rdy,
  output logic                         m_vld,
  output logic [PLD_WIDTH-1:0]         m_pld,
  output logic [ID_WIDTH-1:0]          m_id,
  output logic                         m_last,
  input  logic                         m_rdy
);

  logic [ID_WIDTH-1:0]  ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]  g_idx, g_nxt;
  logic [REQ_NUM-1:0]   gnt;
  logic [PLD_WIDTH-1:0] pld_mux;
  logic                 last_mux;
  logic                 sel_vld, int_rdy, acc;
  rs_beat_t             in_beat, out_beat;

`ifdef RS_ARB_LOCK_EN
  logic                lock_q, lock_d;
  logic [ID_WIDTH-1:0] lock_id_q, lock_id_d;
`endif

  always_comb begin
    gnt = REQ_NUM'(rr_pick(RS_MAX_REQ'(s_vld), RS_PTR_W'(ptr_q)));
`ifdef RS_ARB_LOCK_EN
    if (lock_q) begin
      gnt            = '0;
      gnt[lock_id_q] = 1'b1;
    end
`endif
  end

  always_comb begin
    g_idx    = '0;
    pld_mux  = '0;
    last_mux = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (gnt[i]) begin
        g_idx    = ID_WIDTH'(i);
        pld_mux  = s_pld[i*PLD_WIDTH +: PLD_WIDTH];
        last_mux = s_last[i];
      end
    end
  end

  assign sel_vld = |(gnt & s_vld);
  assign acc     = sel_vld & int_rdy;
  assign s_rdy   = gnt & {REQ_NUM{int_rdy}};
  assign g_nxt   = (g_idx == ID_WIDTH'(REQ_NUM-1)) ? '0
                 : g_idx + ID_WIDTH'(1);

  always_comb begin
    ptr_d = ptr_q;
`ifdef RS_ARB_LOCK_EN
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (acc) begin
      if (last_mux) begin
        lock_d = 1'b0;
        ptr_d  = g_nxt;
      end else begin
        lock_d    = 1'b1;
        lock_id_d = g_idx;
      end
    end
`else
    if (acc) ptr_d = g_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
`ifdef RS_ARB_LOCK_EN
      lock_q    <= 1'b0;
      lock_id_q <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
`ifdef RS_ARB_LOCK_EN
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
`endif
    end
  end

  always_comb begin
    in_beat      = '0;
    in_beat.pld  = RS_BEAT_PLD_W'(pld_mux);
    in_beat.id   = RS_BEAT_ID_W'(g_idx);
    in_beat.last = last_mux;
  end

  rs_rr_arb_slice u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_i     (sel_vld),
    .beat_i    (in_beat),
    .m_rdy_i   (m_rdy),
    .int_rdy_o (int_rdy),
    .m_vld_o   (m_vld),
    .beat_o    (out_beat)
  );

  assign m_pld  = PLD_WIDTH'(out_beat.pld);
  assign m_id   = ID_WIDTH'(out_beat.id);
  assign m_last = out_beat.last;

endmodule

// File: tb/tb_rs_rr_arb.sv
// tb_rs_rr_arb: directed checks for rs_rr_arb (REQ_NUM=4, PLD_WIDTH=32).
module tb_rs_rr_arb;

  logic         clk;
  logic         rst_n;
  logic [3:0]   s_vld;
  logic [127:0] s_pld;
  logic [3:0]   s_last;
  logic [3:0]   s_rdy;
  logic         m_vld;
  logic [31:0]  m_pld;
  logic [1:0]   m_id;
  logic         m_last;
  logic         m_rdy;

  int n_cmp;
  int n_err;

  rs_rr_arb #(
    .REQ_NUM   (4),
    .PLD_WIDTH (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_vld  (s_vld),
    .s_pld  (s_pld),
    .s_last (s_last),
    .s_rdy  (s_rdy),
    .m_vld  (m_vld),
    .m_pld  (m_pld),
    .m_id   (m_id),
    .m_last (m_last),
    .m_rdy  (m_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    s_vld  = '0;
    s_last = '0;
    s_pld  = '0;
    m_rdy  = 1'b1;
    rst_n  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_rdy = 1'b1;
    s_last = '0;
    s_vld = 4'b1111;
    for (int i = 0; i < 4; i++) s_pld[i*32 +: 32] = 32'h50 + i;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (m_vld !== 1'b0) begin
      n_err++; $display("FAIL rst_m_vld: got %0h want 0", m_vld);
    end
    n_cmp++;
    if (m_pld !== 32'h0) begin
      n_err++; $display("FAIL rst_m_pld: got %0h want 0", m_pld);
    end
    n_cmp++;
    if (m_id !== 2'd0) begin
      n_err++; $display("FAIL rst_m_id: got %0h want 0", m_id);
    end
    n_cmp++;
    if (m_last !== 1'b0) begin
      n_err++; $display("FAIL rst_m_last: got %0h want 0", m_last);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (s_rdy !== 4'b0001) begin
      n_err++; $display("FAIL rst_s_rdy: got %0h want 1", s_rdy);
    end
    @(posedge clk);
    #1 s_vld = '0;
    @(negedge clk);
    n_cmp++;
    if (m_vld !== 1'b1 || m_id !== 2'd0 || m_pld !== 32'h50) begin
      n_err++;
      $display("FAIL rst_first_beat: got vld=%0h id=%0h pld=%0h want 1/0/50",
               m_vld, m_id, m_pld);
    end
  endtask

  task automatic test_contention();
    int exp_id [6];
    exp_id = '{0, 1, 2, 3, 0, 1};
    do_reset();
    s_vld = 4'b1111;
    for (int i = 0; i < 4; i++) s_pld[i*32 +: 32] = i;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (m_vld !== 1'b1 || m_id !== 2'(exp_id[k])
          || m_pld !== 32'(exp_id[k])) begin
        n_err++;
        $display("FAIL contention[%0d]: got vld=%0h id=%0h pld=%0h want id %0d",
                 k, m_vld, m_id, m_pld, exp_id[k]);
      end
    end
    s_vld = '0;
  endtask

  task automatic test_sparse();
    logic [3:0]  exp_rdy [3];
    int          exp_id  [3];
    logic [31:0] exp_pld [3];
    exp_rdy = '{4'b0001, 4'b0010, 4'b0001};
    exp_id  = '{1, 0, 1};
    exp_pld = '{32'h11, 32'hA0, 32'hA1};
    do_reset();
    s_vld = 4'b0010;
    s_pld[1*32 +: 32] = 32'h11;
    @(negedge clk);
    n_cmp++;
    if (s_rdy !== 4'b0010) begin
      n_err++; $display("FAIL sparse_setup_rdy: got %0h want 2", s_rdy);
    end
    @(posedge clk);
    #1;
    s_vld = 4'b0011;
    s_pld[0*32 +: 32] = 32'hA0;
    s_pld[1*32 +: 32] = 32'hA1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (s_rdy !== exp_rdy[k] || m_id !== 2'(exp_id[k])
          || m_pld !== exp_pld[k]) begin
        n_err++;
        $display("FAIL sparse[%0d]: got rdy=%0h id=%0h pld=%0h want %0h/%0d/%0h",
                 k, s_rdy, m_id, m_pld, exp_rdy[k], exp_id[k], exp_pld[k]);
      end
      @(posedge clk);
      #1;
    end
    s_vld = '0;
    @(negedge clk);
    n_cmp++;
    if (m_id !== 2'd0 || m_pld !== 32'hA0) begin
      n_err++;
      $display("FAIL sparse_tail: got id=%0h pld=%0h want 0/a0", m_id, m_pld);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  exp_rdy [7];
    logic        exp_vld [7];
    logic [31:0] exp_pld [7];
    logic [31:0] nxt;
    exp_rdy = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
    exp_vld = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_pld = '{32'h0, 32'h100, 32'h100, 32'h100, 32'h101, 32'h102, 32'h0};
    do_reset();
    m_rdy = 1'b0;
    nxt   = 32'h100;
    s_vld = 4'b0001;
    s_pld[0 +: 32] = nxt;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      n_cmp++;
      if (s_rdy !== exp_rdy[c] || m_vld !== exp_vld[c]) begin
        n_err++;
        $display("FAIL bp_hs[%0d]: got rdy=%0h vld=%0h want %0h/%0h",
                 c, s_rdy, m_vld, exp_rdy[c], exp_vld[c]);
      end
      if (exp_vld[c]) begin
        n_cmp++;
        if (m_pld !== exp_pld[c]) begin
          n_err++;
          $display("FAIL bp_pld[%0d]: got %0h want %0h", c, m_pld, exp_pld[c]);
        end
      end
      @(posedge clk);
      #1;
      if (exp_rdy[c][0]) begin
        nxt = nxt + 32'd1;
        s_pld[0 +: 32] = nxt;
      end
      if (c == 2) m_rdy = 1'b1;
      if (c == 4) s_vld = '0;
    end
  endtask

  task automatic test_midreset();
    do_reset();
    m_rdy = 1'b0;
    s_vld = 4'b0001;
    s_pld[0 +: 32] = 32'h200;
    @(posedge clk);
    #1 s_pld[0 +: 32] = 32'h201;
    @(posedge clk);
    #1 s_vld = '0;
    @(negedge clk);
    n_cmp++;
    if (m_vld !== 1'b1 || m_pld !== 32'h200 || s_rdy !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_full: got vld=%0h pld=%0h rdy=%0h want 1/200/0",
               m_vld, m_pld, s_rdy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (m_vld !== 1'b0 || m_pld !== 32'h0) begin
      n_err++;
      $display("FAIL mid_async: got vld=%0h pld=%0h want 0/0", m_vld, m_pld);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_rdy = 1'b1;
    s_vld = 4'b1111;
    for (int i = 0; i < 4; i++) s_pld[i*32 +: 32] = 32'h300 + i;
    @(posedge clk);
    #1 s_vld = '0;
    @(negedge clk);
    n_cmp++;
    if (m_vld !== 1'b1 || m_id !== 2'd0 || m_pld !== 32'h300) begin
      n_err++;
      $display("FAIL mid_ptr0: got vld=%0h id=%0h pld=%0h want 1/0/300",
               m_vld, m_id, m_pld);
    end
  endtask

  task automatic test_lock();
    int          exp_id   [5];
    logic [31:0] exp_pld  [5];
    logic        exp_last [5];
    int          i1, i2;
    logic        a1, a2;
`ifdef RS_ARB_LOCK_EN
    exp_id   = '{1, 1, 1, 2, 2};
    exp_pld  = '{32'h10, 32'h11, 32'h12, 32'h20, 32'h21};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    exp_id   = '{1, 2, 1, 2, 1};
    exp_pld  = '{32'h10, 32'h20, 32'h11, 32'h21, 32'h12};
    exp_last = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
    do_reset();
    i1 = 0;
    i2 = 0;
    s_vld = 4'b0110;
    s_pld[1*32 +: 32] = 32'h10;
    s_pld[2*32 +: 32] = 32'h20;
    s_last = 4'b0100;
    @(negedge clk);
    a1 = s_rdy[1] & s_vld[1];
    a2 = s_rdy[2] & s_vld[2];
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (a1) begin
        i1++;
        if (i1 == 3) s_vld[1] = 1'b0;
        else begin
          s_pld[1*32 +: 32] = 32'h10 + 32'(i1);
          s_last[1] = (i1 == 2);
        end
      end
      if (a2) begin
        i2++;
        s_pld[2*32 +: 32] = 32'h20 + 32'(i2);
      end
      @(negedge clk);
      n_cmp++;
      if (m_vld !== 1'b1 || m_id !== 2'(exp_id[k]) || m_pld !== exp_pld[k]
          || m_last !== exp_last[k]) begin
        n_err++;
        $display("FAIL lock[%0d]: got id=%0h pld=%0h last=%0h want %0d/%0h/%0h",
                 k, m_id, m_pld, m_last, exp_id[k], exp_pld[k], exp_last[k]);
      end
      a1 = s_rdy[1] & s_vld[1];
      a2 = s_rdy[2] & s_vld[2];
    end
    s_vld = '0;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    s_vld  = '0;
    s_pld  = '0;
    s_last = '0;
    m_rdy  = 1'b1;
    test_reset();
    test_contention();
    test_sparse();
    test_backpressure();
    test_midreset();
    test_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
